// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode, operand forwarding and load-use bubbling.
// Optional macro RV32M_EN: decode funct7=0000001 R-type as MUL..REMU; undefined, those encodings are illegal.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [31:0]           id_instr_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic [XLEN-1:0]       exmem_result_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [XLEN-1:0]       memwb_data_i,
  output logic                  load_use_stall_o,
  output logic                  ex_valid_o,
  output logic [XLEN-1:0]       opr_1,
  output logic [XLEN-1:0]       opr_2,
  output logic [3:0]            alu_op,
  output logic                  flag,
  output logic                  eq,
  output logic                  ex_is_branch_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_reg_write_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [XLEN-1:0]       ex_store_data_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic                  ex_illegal_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // One EX slot; an all-zero value is a bubble.
  typedef struct packed {
    logic                  valid;
    logic [3:0]            alu_op;
    logic                  flag;
    logic                  eq;
    logic                  is_branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  illegal;
    logic                  sel_pc;
    logic                  sel_zero;
    logic                  sel_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
  } ex_t;

  ex_t        ex_q;
  ex_t        dec;
  logic [6:0] id_op;
  logic [2:0] id_f3;

  assign id_op = id_instr_i[6:0];
  assign id_f3 = id_instr_i[14:12];

  always_comb begin
    dec = '0;
    if (id_valid_i) begin
      dec.valid    = 1'b1;
      dec.eq       = ~id_instr_i[14] ^ id_instr_i[12];
      dec.rd       = id_instr_i[11:7];
      dec.rs1      = id_instr_i[19:15];
      dec.rs2      = id_instr_i[24:20];
      dec.rs1_data = id_rs1_data_i;
      dec.rs2_data = id_rs2_data_i;
      dec.imm      = id_imm_i;
      dec.pc       = id_pc_i;
      case (id_op)
        OP_R: begin
          dec.sel_rs2   = 1'b1;
          dec.reg_write = 1'b1;
          if (id_instr_i[31:25] == 7'b0000001) begin
`ifdef RV32M_EN
            dec.alu_op = {1'b1, id_f3};
`else
            dec.alu_op    = {1'b0, id_f3};
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
`endif
          end else begin
            dec.alu_op = {id_instr_i[25], id_f3};
            dec.flag   = (id_f3 == 3'b000 || id_f3 == 3'b101) ? id_instr_i[30] : 1'b0;
          end
        end
        OP_I: begin
          dec.alu_op    = {1'b0, id_f3};
          dec.flag      = (id_f3 == 3'b101) ? id_instr_i[30] : 1'b0;
          dec.reg_write = 1'b1;
        end
        OP_BR: begin
          dec.alu_op    = {2'b00, id_f3[2:1]};
          dec.flag      = (id_f3[2:1] == 2'b00);
          dec.is_branch = 1'b1;
          dec.sel_rs2   = 1'b1;
        end
        OP_LOAD: begin
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_STORE: dec.mem_write = 1'b1;
        OP_LUI: begin
          dec.sel_zero  = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          dec.sel_pc    = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_JAL, OP_JALR: dec.reg_write = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Hazard: the EX load's result is not ready for an ID instruction that reads it.
  logic id_uses_rs2;
  assign id_uses_rs2 = (id_op == OP_R) || (id_op == OP_BR) || (id_op == OP_STORE);
  assign load_use_stall_o = !flush_i && id_valid_i && ex_q.valid && ex_q.mem_read &&
                            (ex_q.rd != '0) &&
                            ((ex_q.rd == id_instr_i[19:15]) ||
                             (id_uses_rs2 && (ex_q.rd == id_instr_i[24:20])));

  // Handshake: id_valid_i offers an instruction; it is taken at posedge unless
  // flush_i, stall_i or load_use_stall_o is high (ID must hold while stalled).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (stall_i) begin
      ex_q <= ex_q;
    end else if (load_use_stall_o) begin
      ex_q <= '0;
    end else begin
      ex_q <= dec;
    end
  end

  logic            fwd1_ex, fwd1_wb, fwd2_ex, fwd2_wb;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign fwd1_ex = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rs1);
  assign fwd1_wb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rs1);
  assign fwd2_ex = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rs2);
  assign fwd2_wb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rs2);

  assign rs1_fwd = fwd1_ex ? exmem_result_i : (fwd1_wb ? memwb_data_i : ex_q.rs1_data);
  assign rs2_fwd = fwd2_ex ? exmem_result_i : (fwd2_wb ? memwb_data_i : ex_q.rs2_data);

  assign opr_1 = ex_q.sel_pc ? ex_q.pc : (ex_q.sel_zero ? '0 : rs1_fwd);
  assign opr_2 = ex_q.sel_rs2 ? rs2_fwd : ex_q.imm;

  assign ex_valid_o      = ex_q.valid;
  assign alu_op          = ex_q.alu_op;
  assign flag            = ex_q.flag;
  assign eq              = ex_q.eq;
  assign ex_is_branch_o  = ex_q.is_branch;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_rd_o         = ex_q.rd;
  assign ex_store_data_o = rs2_fwd;
  assign ex_pc_o         = ex_q.pc;
  assign ex_illegal_o    = ex_q.illegal;

endmodule
